// File: rtl/spi_pkg.sv
// Shared state encoding and sizing constants for the SPI master controller.
package spi_pkg;

    localparam int DATA_W       = 8;
    localparam int SHIFT_PHASES = 16;
    localparam int XFER_PHASES  = 19;
    localparam int CS_MAX       = 16;
    localparam int SEL_W        = $clog2(CS_MAX);

    typedef enum logic [2:0] {
        FLUSH,
        IDLE,
        SETUP,
        SHIFT,
        DESEL,
        COMMIT,
        DONE
    } state_t;

endpackage

// File: rtl/spi_phase_tick.sv
// Phase timer: one-cycle tick at the end of every CLK_DIV-cycle phase.
module spi_phase_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && !clr && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// 8-bit SPI transfer sequencer: flush, select, shift, deselect, commit pulse.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int NUM_SLAVES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [SEL_W-1:0]      req_sel,
    input  logic [DATA_W-1:0]     req_data,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_err,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic [NUM_SLAVES-1:0] cs_n
);

    localparam int PH_W = $clog2(SHIFT_PHASES);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(SHIFT_PHASES - 1);

    state_t              state, state_nxt;
    logic [PH_W-1:0]     ph, ph_nxt;
    logic [SEL_W-1:0]    sel_q, sel_nxt;
    logic [DATA_W-1:0]   data_q, data_nxt;
    logic [DATA_W-1:0]   rx_q, rx_nxt;
    logic                armed;
    logic                tick;
    logic                drive;
    logic                sel_bad;
    logic                sclk_d;
    logic                mosi_d;
    logic [NUM_SLAVES-1:0] cs_d;

    // Holds the phase counter for the first post-reset cycle so FLUSH gets a full phase.
    spi_phase_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .en  (armed),
        .clr (state == IDLE || state == DONE),
        .tick(tick)
    );

    assign sel_bad = int'(sel_q) >= NUM_SLAVES;

    always_comb begin
        state_nxt = state;
        ph_nxt    = ph;
        sel_nxt   = sel_q;
        data_nxt  = data_q;
        rx_nxt    = rx_q;
        unique case (state)
            FLUSH: begin
                if (tick) begin
                    if (ph[0]) begin
                        state_nxt = IDLE;
                        ph_nxt    = '0;
                    end else begin
                        ph_nxt = ph + 1'b1;
                    end
                end
            end
            IDLE: begin
                if (req_valid) begin
                    state_nxt = SETUP;
                    ph_nxt    = '0;
                    sel_nxt   = req_sel;
                    data_nxt  = req_data;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_nxt = SHIFT;
                    ph_nxt    = '0;
                end
            end
            SHIFT: begin
                // ph[0]=0 is the high half; its end is the falling edge.
                if (tick) begin
                    if (!ph[0]) begin
                        rx_nxt[ph[PH_W-1:1]] = miso;
                    end
                    if (ph == PH_LAST) begin
                        state_nxt = DESEL;
                        ph_nxt    = '0;
                    end else begin
                        ph_nxt = ph + 1'b1;
                    end
                end
            end
            DESEL: begin
                if (tick) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                if (tick) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = FLUSH;
                ph_nxt    = '0;
            end
        endcase
    end

    // Pin values are decoded from the next state and registered, so they glitch-free track state.
    always_comb begin
        drive  = (state_nxt == SETUP) || (state_nxt == SHIFT);
        sclk_d = ((state_nxt == FLUSH || state_nxt == SHIFT) && !ph_nxt[0])
                 || (state_nxt == COMMIT);
        mosi_d = drive && data_nxt[ph_nxt[PH_W-1:1]];
        cs_d   = '1;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (drive && sel_nxt == SEL_W'(i)) begin
                cs_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FLUSH;
            ph        <= '0;
            sel_q     <= '0;
            data_q    <= '0;
            rx_q      <= '0;
            armed     <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            cs_n      <= '1;
        end else begin
            state     <= state_nxt;
            ph        <= ph_nxt;
            sel_q     <= sel_nxt;
            data_q    <= data_nxt;
            rx_q      <= rx_nxt;
            armed     <= 1'b1;
            req_ready <= (state_nxt == IDLE);
            rsp_valid <= (state_nxt == DONE);
            if (state_nxt == DONE) begin
                rsp_data <= rx_nxt;
                rsp_err  <= sel_bad;
            end
            sclk      <= sclk_d;
            mosi      <= mosi_d;
            cs_n      <= cs_d;
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench: two controllers (CLK_DIV=2 and 1) on a muxed bus of four slave models.
module tb_spi_master_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       req_valid_a = 1'b0, req_valid_b = 1'b0;
    logic [3:0] req_sel_a = '0, req_sel_b = '0;
    logic [7:0] req_data_a = '0, req_data_b = '0;
    logic       req_ready_a, req_ready_b;
    logic       rsp_valid_a, rsp_valid_b;
    logic [7:0] rsp_data_a, rsp_data_b;
    logic       rsp_err_a, rsp_err_b;
    logic       sclk_a, sclk_b, mosi_a, mosi_b;
    logic [3:0] cs_n_a, cs_n_b;
    logic       miso;

    spi_master_ctrl #(.CLK_DIV(2), .NUM_SLAVES(4)) u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_sel(req_sel_a), .req_data(req_data_a),
        .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a), .rsp_err(rsp_err_a),
        .sclk(sclk_a), .mosi(mosi_a), .miso(miso), .cs_n(cs_n_a)
    );

    spi_master_ctrl #(.CLK_DIV(1), .NUM_SLAVES(4)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_sel(req_sel_b), .req_data(req_data_b),
        .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .rsp_err(rsp_err_b),
        .sclk(sclk_b), .mosi(mosi_b), .miso(miso), .cs_n(cs_n_b)
    );

    // Slaves see whichever controller is switched onto the bus.
    logic       use_b = 1'b0;
    logic       bsclk, bmosi;
    logic [3:0] bcs;
    assign bsclk = use_b ? sclk_b : sclk_a;
    assign bmosi = use_b ? mosi_b : mosi_a;
    assign bcs   = use_b ? cs_n_b : cs_n_a;

    logic [7:0] s_tx  [4] = '{8'h81, 8'h3C, 8'h96, 8'h7E};
    logic [7:0] s_sr  [4] = '{default: 8'h00};
    logic [7:0] s_out [4] = '{default: 8'h00};
    int         s_fall[4] = '{default: 0};
    int         s_rise[4] = '{default: 0};

    // Slave: shift MOSI on falling edges; a falling edge while deselected commits 8 bits.
    always @(negedge bsclk) begin
        for (int i = 0; i < 4; i++) begin
            if (!bcs[i]) begin
                s_sr[i]   <= {bmosi, s_sr[i][7:1]};
                s_fall[i] <= s_fall[i] + 1;
            end else begin
                if (s_fall[i] == 8) s_out[i] <= s_sr[i];
                s_fall[i] <= 0;
            end
        end
    end

    always @(posedge bsclk) begin
        for (int i = 0; i < 4; i++) begin
            s_rise[i] <= bcs[i] ? 0 : s_rise[i] + 1;
        end
    end

    always_comb begin
        miso = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (!bcs[i]) miso = s_tx[i][(s_rise[i] == 0) ? 0 : s_rise[i] - 1];
        end
    end

    int cs_low_cnt[4] = '{default: 0};
    int rsp_cnt_a = 0;
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!bcs[i]) cs_low_cnt[i] <= cs_low_cnt[i] + 1;
        end
        if (rsp_valid_a) rsp_cnt_a <= rsp_cnt_a + 1;
    end

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         due;
    } exp_t;
    exp_t sbq[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic accept(input bit b, input logic [3:0] sel, input logic [7:0] data,
                          input logic [7:0] exp, input logic err, input bit keep,
                          input bit push, output int t);
        if (b) begin
            req_valid_b = 1'b1; req_sel_b = sel; req_data_b = data;
        end else begin
            req_valid_a = 1'b1; req_sel_a = sel; req_data_a = data;
        end
        t = -1;
        for (int k = 0; k < 200; k++) begin
            if ((b ? req_ready_b : req_ready_a) === 1'b1) begin
                t = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("accept_seen", 32'(t >= 0), 32'd1);
        if (t >= 0 && push) sbq.push_back('{data: exp, err: err, due: t + (b ? 20 : 39)});
        @(negedge clk);
        if (!keep) begin
            if (b) req_valid_b = 1'b0;
            else req_valid_a = 1'b0;
        end
    endtask

    task automatic get_rsp(input bit b, input string tag, output int r);
        exp_t e;
        r = -1;
        for (int k = 0; k < 100; k++) begin
            if ((b ? rsp_valid_b : rsp_valid_a) === 1'b1) begin
                r = cyc;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_seen"}, 32'(r >= 0), 32'd1);
        if (r >= 0 && sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({tag, "_latency"}, 32'(r), 32'(e.due));
            chk({tag, "_data"}, 32'(b ? rsp_data_b : rsp_data_a), 32'(e.data));
            chk({tag, "_err"}, 32'(b ? rsp_err_b : rsp_err_a), 32'(e.err));
        end
    endtask

    function automatic logic [3:0] low_mask(input int snap[4]);
        logic [3:0] m;
        for (int i = 0; i < 4; i++) m[i] = (cs_low_cnt[i] != snap[i]);
        return m;
    endfunction

    logic [4:0] fl_rdy  = 5'b10000;
    logic [4:0] fl_sclk = 5'b00011;

    initial begin
        int t1, t2, r1, r2, n0;
        int snap[4];

        repeat (3) @(negedge clk);
        chk("reset_outputs",
            32'({req_ready_a, rsp_valid_a, rsp_data_a, rsp_err_a, sclk_a, mosi_a, cs_n_a}),
            32'({1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'hF}));

        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("flush_seq", 32'({req_ready_a, sclk_a, cs_n_a}),
                32'({fl_rdy[c], fl_sclk[c], 4'hF}));
            if (c == 1) chk("flush_b_busy", 32'(req_ready_b), 32'd0);
            if (c == 2) chk("flush_b_ready", 32'(req_ready_b), 32'd1);
        end

        snap = cs_low_cnt;
        accept(1'b0, 4'd1, 8'hA5, 8'h3C, 1'b0, 1'b0, 1'b1, t1);
        get_rsp(1'b0, "a5", r1);
        chk("a5_slave_rx", 32'(s_out[1]), 32'hA5);
        chk("a5_cs_mask", 32'(low_mask(snap)), 32'b0010);
        chk("a5_cs_len", 32'(cs_low_cnt[1] - snap[1]), 32'd34);

        accept(1'b0, 4'd0, 8'h01, 8'h81, 1'b0, 1'b1, 1'b1, t1);
        req_sel_a  = 4'd3;
        req_data_a = 8'hFF;
        get_rsp(1'b0, "b2b0", r1);
        accept(1'b0, 4'd3, 8'hFF, 8'h7E, 1'b0, 1'b0, 1'b1, t2);
        chk("b2b_gap", 32'(t2), 32'(r1 + 1));
        get_rsp(1'b0, "b2b1", r2);
        chk("b2b_slave0", 32'(s_out[0]), 32'h01);
        chk("b2b_slave3", 32'(s_out[3]), 32'hFF);
        chk("b2b_slave1", 32'(s_out[1]), 32'hA5);

        snap = cs_low_cnt;
        accept(1'b0, 4'd7, 8'h55, 8'hFF, 1'b1, 1'b0, 1'b1, t1);
        get_rsp(1'b0, "badsel", r1);
        chk("badsel_cs", 32'(low_mask(snap)), 32'b0000);

        accept(1'b0, 4'd2, 8'h33, 8'h00, 1'b0, 1'b0, 1'b0, t1);
        repeat (18) @(negedge clk);
        chk("abort_bit4_high", 32'({sclk_a, cs_n_a}), 32'({1'b1, 4'b1011}));
        n0 = rsp_cnt_a;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_idle_pins", 32'({sclk_a, cs_n_a}), 32'({1'b0, 4'hF}));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_flush_pulse", 32'({sclk_a, cs_n_a}), 32'({1'b1, 4'hF}));
        repeat (4) @(negedge clk);
        chk("abort_ready", 32'(req_ready_a), 32'd1);
        chk("abort_no_rsp", 32'(rsp_cnt_a - n0), 32'd0);
        chk("abort_no_commit", 32'(s_out[2]), 32'h00);
        accept(1'b0, 4'd2, 8'h5A, 8'h96, 1'b0, 1'b0, 1'b1, t1);
        get_rsp(1'b0, "post_abort", r1);
        chk("post_abort_slave", 32'(s_out[2]), 32'h5A);

        use_b = 1'b1;
        @(negedge clk);
        accept(1'b1, 4'd1, 8'hC3, 8'h3C, 1'b0, 1'b0, 1'b1, t1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("div1_sclk", 32'(sclk_b), 32'(c % 2 == 0));
        end
        get_rsp(1'b1, "div1", r1);
        chk("div1_slave_rx", 32'(s_out[1]), 32'hC3);
        chk("div1_sb_empty", 32'(sbq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "bench did not finish");
    end

endmodule
